// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register dump engine: FSM state encoding,
// the per-register byte count and the byte-lane selector.
package reg_dump_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETADDR = 2'd1,
    SEND    = 2'd2,
    DONE    = 2'd3
  } state_e;

  // One index byte followed by the four data bytes, most significant first.
  localparam int unsigned BYTES_PER_REG = 5;
  localparam logic [2:0]  LAST_BYTE_IDX = 3'(BYTES_PER_REG - 1);

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd1:    b = word[31:24];
      3'd2:    b = word[23:16];
      3'd3:    b = word[15:8];
      3'd4:    b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/reg_dump.sv
// Walks the core's debug read port from FIRST_REG to LAST_REG and streams
// each register as {index, byte3, byte2, byte1, byte0} over a valid/ready sink.
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] regout,
  output logic [4:0]  addrout,
  output logic        busy,
  output logic        done,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

  state_e      state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  idx_q, idx_d;
  logic        armed_q;

  // State and datapath registers; armed_q masks start for the first clock after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= 5'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      word_q     <= 32'h0000_0000;
      idx_q      <= 3'd0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      armed_q    <= 1'b1;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    word_d     = word_q;
    idx_d      = idx_q;

    case (state_q)
      IDLE: begin
        if (start && armed_q) begin
          state_d = SETADDR;
          addr_d  = FIRST_ADDR;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      // addrout has been stable for a full cycle, so regout is safe to capture.
      SETADDR: begin
        word_d     = regout;
        tx_data_d  = {3'b000, addr_q};
        tx_valid_d = 1'b1;
        idx_d      = 3'd0;
        state_d    = SEND;
      end

      SEND: begin
        if (tx_valid_q && tx_ready) begin
          if (idx_q == LAST_BYTE_IDX) begin
            tx_valid_d = 1'b0;
            if (addr_q == LAST_ADDR) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              addr_d  = addr_q + 5'd1;
              state_d = SETADDR;
            end
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = word_byte(word_q, idx_q + 3'd1);
          end
        end else begin
          state_d = SEND;
        end
      end

      // start is deliberately not looked at here; IDLE must be visited first.
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  assign addrout  = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule
